// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_pkg
// Description : Shared sizes, FSM encodings and MMIO map for the MNIST
//               accelerator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    localparam int c_N_WORDS   = 785;
    localparam int c_N_CLASSES = 10;
    localparam int c_DATA_W    = 32;
    localparam int c_ADDR_W    = 10;
    localparam int c_IDX_W     = 4;
    localparam int c_CNT_W     = 16;

    // MMIO map decoded by axi4_mem_periph
    localparam logic [31:0] c_MMIO_IMAGE_BASE = 32'h3400_0000;
    localparam logic [31:0] c_MMIO_CONTROL    = 32'h3100_0000;
    localparam logic [31:0] c_MMIO_STATUS     = 32'h3200_0000;
    localparam logic [31:0] c_MMIO_SCORES     = 32'h3300_0000;
    localparam logic [31:0] c_MMIO_CLASS      = 32'h3300_0028;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_RST    = 3'd1;
    localparam state_t c_ST_WAIT   = 3'd2;
    localparam state_t c_ST_CAP    = 3'd3;
    localparam state_t c_ST_ARGMAX = 3'd4;
    localparam state_t c_ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/accel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : accel_ctrl_if
// Description : Firmware-facing MMIO bundle: image writes, run control,
//               score readback and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface accel_ctrl_if;
    import accel_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [c_DATA_W-1:0] wr_data;
    logic                start;
    logic [c_IDX_W-1:0]  rd_idx;
    logic [c_DATA_W-1:0] rd_score;
    logic                busy;
    logic                done;
    logic                timeout_err;
    logic [c_IDX_W-1:0]  class_idx;

    modport master (
        output wr_valid, wr_addr, wr_data, start, rd_idx,
        input  wr_ready, rd_score, busy, done, timeout_err, class_idx
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, start, rd_idx,
        output wr_ready, rd_score, busy, done, timeout_err, class_idx
    );

endinterface
`default_nettype wire

// File: rtl/argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : argmax_seq
// Description : Sequential signed argmax, one candidate per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_seq
    import accel_pkg::*;
#(
    parameter int N_CLASSES = c_N_CLASSES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [c_DATA_W-1:0] i_load_val,
    input  logic                i_step,
    input  logic [c_DATA_W-1:0] i_step_val,
    output logic [c_IDX_W-1:0]  o_k,
    output logic                o_last,
    output logic [c_IDX_W-1:0]  o_next_idx
);

    logic [c_IDX_W-1:0]  r_k;
    logic [c_IDX_W-1:0]  r_best_idx;
    logic [c_DATA_W-1:0] r_best_val;
    logic                w_take;

    // Strictly greater, so ties keep the earlier index
    assign w_take = $signed(i_step_val) > $signed(r_best_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (i_load) begin
            r_k        <= c_IDX_W'(1);
            r_best_idx <= '0;
            r_best_val <= i_load_val;
        end else if (i_step) begin
            r_k <= r_k + c_IDX_W'(1);
            if (w_take) begin
                r_best_idx <= r_k;
                r_best_val <= i_step_val;
            end
        end
    end

    assign o_k        = r_k;
    assign o_last     = (r_k == c_IDX_W'(N_CLASSES - 1));
    assign o_next_idx = w_take ? r_k : r_best_idx;

endmodule
`default_nettype wire

// File: rtl/accel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accel_ctrl
// Description : Image buffer, run sequencer and score argmax in front of the
//               MNIST accelerator core.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_ctrl
    import accel_pkg::*;
#(
    parameter int N_WORDS    = c_N_WORDS,
    parameter int N_CLASSES  = c_N_CLASSES,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic                            clk,
    input  logic                            reset,
    accel_ctrl_if.slave                     bus,
    output logic [N_WORDS*c_DATA_W-1:0]     in_image,
    output logic                            accel_reset,
    input  logic                            accel_ready,
    input  logic [N_CLASSES*c_DATA_W-1:0]   accel_result
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DATA_W-1:0] r_image  [N_WORDS];
    logic [c_DATA_W-1:0] r_scores [N_CLASSES];
    logic [c_CNT_W-1:0]  r_rst_cnt;
    logic [c_CNT_W-1:0]  r_to_cnt;
    logic                r_done;
    logic                r_timeout_err;
    logic [c_IDX_W-1:0]  r_class_idx;

    logic                w_go;
    logic                w_wait_enter;
    logic                w_cap;
    logic                w_step;
    logic                w_finish;
    logic                w_timeout;
    logic                w_busy;
    logic                w_accel_reset;
    logic                w_wr_open;
    logic                w_wr_en;
    logic                w_rst_last;
    logic                w_wait_first;
    logic                w_to_last;
    logic [c_IDX_W-1:0]  w_k;
    logic                w_arg_last;
    logic [c_IDX_W-1:0]  w_next_idx;

    assign w_rst_last   = (r_rst_cnt == c_CNT_W'(RST_CYCLES - 1));
    assign w_wait_first = (r_to_cnt == '0);
    assign w_to_last    = (r_to_cnt == c_CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_go         = 1'b0;
        w_wait_enter = 1'b0;
        w_cap        = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_RST;
                    w_go        = 1'b1;
                end
            end
            c_ST_RST: begin
                if (w_rst_last) begin
                    w_state_nxt  = c_ST_WAIT;
                    w_wait_enter = 1'b1;
                end
            end
            c_ST_WAIT: begin
                // A ready left over from the previous run is ignored for one cycle
                if (!w_wait_first && accel_ready) begin
                    w_state_nxt = c_ST_CAP;
                end else if (w_to_last) begin
                    w_state_nxt = c_ST_DONE;
                    w_timeout   = 1'b1;
                end
            end
            c_ST_CAP: begin
                w_state_nxt = c_ST_ARGMAX;
                w_cap       = 1'b1;
            end
            c_ST_ARGMAX: begin
                w_step = 1'b1;
                if (w_arg_last) begin
                    w_state_nxt = c_ST_DONE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // The core stays in reset from power-up until the first run leaves RST
    always_comb begin
        w_busy        = 1'b0;
        w_accel_reset = 1'b0;
        w_wr_open     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_accel_reset = 1'b1;
                w_wr_open     = 1'b1;
            end
            c_ST_RST: begin
                w_busy        = 1'b1;
                w_accel_reset = 1'b1;
            end
            c_ST_WAIT, c_ST_CAP, c_ST_ARGMAX: w_busy = 1'b1;
            c_ST_DONE: w_wr_open = 1'b1;
            default:   w_accel_reset = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_cnt     <= '0;
            r_to_cnt      <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_class_idx   <= '0;
        end else begin
            if (w_go) begin
                r_rst_cnt     <= '0;
                r_done        <= 1'b0;
                r_timeout_err <= 1'b0;
            end else if (r_state == c_ST_RST) begin
                r_rst_cnt <= r_rst_cnt + c_CNT_W'(1);
            end
            if (w_wait_enter)                r_to_cnt <= '0;
            else if (r_state == c_ST_WAIT)   r_to_cnt <= r_to_cnt + c_CNT_W'(1);
            if (w_timeout) begin
                r_done        <= 1'b1;
                r_timeout_err <= 1'b1;
            end
            if (w_finish) begin
                r_done      <= 1'b1;
                r_class_idx <= w_next_idx;
            end
        end
    end

    assign w_wr_en = bus.wr_ready && (32'(bus.wr_addr) < N_WORDS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_WORDS; j++) r_image[j] <= '0;
        end else if (w_wr_en) begin
            r_image[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_CLASSES; k++) r_scores[k] <= '0;
        end else if (w_cap) begin
            for (int k = 0; k < N_CLASSES; k++)
                r_scores[k] <= accel_result[k*c_DATA_W +: c_DATA_W];
        end
    end

    // Score 0 seeds the compare straight from the bus while the bank loads
    argmax_seq #(
        .N_CLASSES (N_CLASSES)
    ) u_argmax (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cap),
        .i_load_val (accel_result[c_DATA_W-1:0]),
        .i_step     (w_step),
        .i_step_val (r_scores[w_k]),
        .o_k        (w_k),
        .o_last     (w_arg_last),
        .o_next_idx (w_next_idx)
    );

    for (genvar j = 0; j < N_WORDS; j++) begin : g_img
        assign in_image[j*c_DATA_W +: c_DATA_W] = r_image[j];
    end

    assign bus.wr_ready    = w_wr_open & bus.wr_valid;
    assign bus.rd_score    = (32'(bus.rd_idx) < N_CLASSES) ? r_scores[bus.rd_idx] : '0;
    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.class_idx   = r_class_idx;
    assign accel_reset     = w_accel_reset;

endmodule
`default_nettype wire
